max7219_receiver: RTL and testbench

Serial-frame receiver for the MAX7219 display-driver interface: the display end of the link the frequency counter drives with clko/dout/load. Oversamples the three serial lines on the system clock, assembles 16-bit MSB-first frames, and on each load rising edge decodes the frame into the MAX7219 register file. It drives per-digit segment patterns, which makes it usable as an on-chip display emulator and as a self-checking bench partner for any MAX7219 writer in the codebase.

---
 rtl/max7219_pkg.sv | 33 +++
 rtl/max7219_receiver_if.sv | 8 +
 rtl/max7219_code_b.sv | 10 +
 rtl/max7219_receiver.sv | 85 ++++++++
 tb/tb_max7219_receiver.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/max7219_pkg.sv
// max7219_pkg: MAX7219 register map, segment bit order and Code B font
package max7219_pkg;
   localparam logic [3:0] ADDR_NOOP         = 4'h0;
   localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
   localparam logic [3:0] ADDR_DIGIT1       = 4'h2;
   localparam logic [3:0] ADDR_DIGIT2       = 4'h3;
   localparam logic [3:0] ADDR_DIGIT3       = 4'h4;
   localparam logic [3:0] ADDR_DIGIT4       = 4'h5;
   localparam logic [3:0] ADDR_DIGIT5       = 4'h6;
   localparam logic [3:0] ADDR_DIGIT6       = 4'h7;
   localparam logic [3:0] ADDR_DIGIT7       = 4'h8;
   localparam logic [3:0] ADDR_DECODE       = 4'h9;
   localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
   localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
   localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
   localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;
   localparam int SEG_DP = 7;
   localparam int SEG_A  = 6;
   localparam int SEG_B  = 5;
   localparam int SEG_C  = 4;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 2;
   localparam int SEG_F  = 1;
   localparam int SEG_G  = 0;
   // entry [c] holds segments A..G for code c; codes A..F are -,E,H,L,P,blank
   localparam logic [15:0][6:0] CODE_B = {
      7'h00, 7'h67, 7'h0E, 7'h37, 7'h4F, 7'h01, 7'h7B, 7'h7F,
      7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
   };
   function automatic logic [6:0] code_b_segs(input logic [3:0] code);
      return CODE_B[code];
   endfunction
endpackage

// File: rtl/max7219_receiver_if.sv
// max7219_receiver_if: three-wire MAX7219 serial link (clko/dout/load)
interface max7219_receiver_if;
   logic sclk;
   logic din;
   logic load;
   modport master (output sclk, din, load);
   modport slave  (input  sclk, din, load);
endinterface

// File: rtl/max7219_code_b.sv
// max7219_code_b: Code B font lookup with decimal point
module max7219_code_b
   import max7219_pkg::*;
(
   input  logic [3:0] code,
   input  logic       dp,
   output logic [7:0] pattern
);
   assign pattern = {dp, code_b_segs(code)};
endmodule

// File: rtl/max7219_receiver.sv
// max7219_receiver: oversampling MAX7219 frame receiver, register file and segment driver
module max7219_receiver
   import max7219_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   max7219_receiver_if.slave ser,
   output logic              frame_valid,
   output logic [15:0]       frame_data,
   output logic              frame_error,
   output logic [7:0]        decode_mode,
   output logic [3:0]        intensity,
   output logic [2:0]        scan_limit,
   output logic              shutdown,
   output logic              display_test,
   output logic [63:0]       segments
);
   localparam int WW = $clog2(SYNC_STAGES + 2);
   logic [SYNC_STAGES-1:0] sclk_sync, din_sync, load_sync;
   logic                   sclk_d, din_d, load_d, sclk_rise, load_rise;
   logic [WW-1:0]          warm;
   logic                   armed;
   logic [15:0]            shift_reg;
   logic [4:0]             bit_cnt;
   logic [7:0][7:0]        digit;
   logic [3:0]             addr;
   logic [7:0]             value;
   // edges are suppressed until the edge flops have seen the post-reset pin levels
   assign armed = warm == WW'(SYNC_STAGES + 1);
   assign addr  = shift_reg[11:8];
   assign value = shift_reg[7:0];
   always_ff @(posedge clk) begin
      if (reset) begin
         {sclk_sync, din_sync, load_sync} <= '0;
         {sclk_d, din_d, load_d, sclk_rise, load_rise} <= '0;
         warm <= '0;
         shift_reg <= '0;
         bit_cnt <= '0;
         digit <= '0;
         frame_valid <= 1'b0;
         frame_data <= '0;
         frame_error <= 1'b0;
         decode_mode <= '0;
         intensity <= '0;
         scan_limit <= '0;
         shutdown <= 1'b1;
         display_test <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ser.sclk};
         din_sync <= {din_sync[SYNC_STAGES-2:0], ser.din};
         load_sync <= {load_sync[SYNC_STAGES-2:0], ser.load};
         sclk_d <= sclk_sync[SYNC_STAGES-1];
         din_d <= din_sync[SYNC_STAGES-1];
         load_d <= load_sync[SYNC_STAGES-1];
         sclk_rise <= armed && sclk_sync[SYNC_STAGES-1] && !sclk_d;
         load_rise <= armed && load_sync[SYNC_STAGES-1] && !load_d;
         warm <= armed ? warm : warm + WW'(1);
         frame_valid <= load_rise;
         // a load rise wins over a coincident sclk rise, whose bit is dropped
         if (load_rise) begin
            frame_data <= shift_reg;
            frame_error <= bit_cnt < 5'd16;
            bit_cnt <= '0;
            if (addr >= ADDR_DIGIT0 && addr <= ADDR_DIGIT7) digit[3'(addr - ADDR_DIGIT0)] <= value;
            if (addr == ADDR_DECODE) decode_mode <= value;
            if (addr == ADDR_INTENSITY) intensity <= value[3:0];
            if (addr == ADDR_SCAN_LIMIT) scan_limit <= value[2:0];
            if (addr == ADDR_SHUTDOWN) shutdown <= ~value[0];
            if (addr == ADDR_DISPLAY_TEST) display_test <= value[0];
         end else if (sclk_rise && !load_d) begin
            shift_reg <= {shift_reg[14:0], din_d};
            bit_cnt <= bit_cnt + 5'(bit_cnt != 5'd31);
         end
      end
   end
   for (genvar k = 0; k < 8; k++) begin : g_dig
      logic [7:0] cb;
      max7219_code_b u_cb (.code(digit[k][3:0]), .dp(digit[k][7]), .pattern(cb));
      assign segments[8*k +: 8] = display_test ? 8'hFF :
                                  (shutdown || 3'(k) > scan_limit) ? 8'h00 :
                                  decode_mode[k] ? cb : digit[k];
   end
endmodule

// File: tb/tb_max7219_receiver.sv
// tb_max7219_receiver: randomized and directed frames against a register-level model
module tb_max7219_receiver;
   logic        clk = 1'b0;
   logic        reset;
   logic        frame_valid, frame_error, shutdown, display_test;
   logic [15:0] frame_data;
   logic [7:0]  decode_mode;
   logic [3:0]  intensity;
   logic [2:0]  scan_limit;
   logic [63:0] segments;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   max7219_receiver_if ser ();
   max7219_receiver #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .ser(ser), .frame_valid(frame_valid), .frame_data(frame_data),
      .frame_error(frame_error), .decode_mode(decode_mode), .intensity(intensity),
      .scan_limit(scan_limit), .shutdown(shutdown), .display_test(display_test), .segments(segments)
   );
   logic [6:0]  cb_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00};
   logic        m_hist [$];
   int          m_cnt;
   logic [7:0]  m_dig [8];
   logic [7:0]  m_dec;
   logic [3:0]  m_int;
   logic [2:0]  m_scan;
   logic        m_shut, m_test, m_err;
   logic [15:0] m_frame;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   function automatic void m_reset();
      m_hist.delete();
      m_cnt = 0;
      for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
      m_dec = 0; m_int = 0; m_scan = 0; m_shut = 1; m_test = 0; m_err = 0; m_frame = 0;
   endfunction
   function automatic void m_load();
      int a;
      for (int i = 0; i < 16; i++) m_frame[i] = (i < m_hist.size()) ? m_hist[m_hist.size() - 1 - i] : 1'b0;
      m_err = m_cnt < 16;
      m_cnt = 0;
      a = int'(m_frame[11:8]);
      if (a >= 1 && a <= 8) m_dig[a - 1] = m_frame[7:0];
      else if (a == 9) m_dec = m_frame[7:0];
      else if (a == 10) m_int = m_frame[3:0];
      else if (a == 11) m_scan = m_frame[2:0];
      else if (a == 12) m_shut = !m_frame[0];
      else if (a == 15) m_test = m_frame[0];
   endfunction
   function automatic logic [63:0] m_segs();
      logic [63:0] s;
      for (int k = 0; k < 8; k++)
         s[8*k +: 8] = m_test ? 8'hFF : (m_shut || k > int'(m_scan)) ? 8'h00 :
                       m_dec[k] ? {m_dig[k][7], cb_tab[m_dig[k][3:0]]} : m_dig[k];
      return s;
   endfunction
   task automatic check_state(input string tag);
      check({tag, "_regs"}, {decode_mode, intensity, scan_limit, shutdown, display_test},
            {m_dec, m_int, m_scan, m_shut, m_test});
      check({tag, "_segs"}, segments, m_segs());
   endtask
   task automatic apply_reset();
      @(negedge clk);
      reset = 1; ser.sclk = 0; ser.din = 0; ser.load = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_valid", frame_valid, 0);
      end
      reset = 0;
      m_reset();
      check("rst_frame", {frame_error, frame_data}, 0);
      check_state("rst");
      repeat (4) @(negedge clk);
   endtask
   task automatic sclk_bit(input logic b);
      ser.din = b;
      repeat (4) @(negedge clk);
      ser.sclk = 1;
      m_hist.push_back(b);
      if (m_hist.size() > 16) void'(m_hist.pop_front());
      m_cnt++;
      repeat (4) @(negedge clk);
      ser.sclk = 0;
   endtask
   task automatic send(input int n, input logic [31:0] v);
      for (int i = n - 1; i >= 0; i--) sclk_bit(v[i]);
   endtask
   task automatic do_load(input bit coincide);
      logic found = 0;
      repeat (3) @(negedge clk);
      if (coincide) begin
         ser.din = 1'($urandom);
         repeat (4) @(negedge clk);
         ser.sclk = 1;
      end
      ser.load = 1;
      m_load();
      for (int i = 0; i < 12 && !found; i++) begin
         @(negedge clk);
         found = frame_valid;
      end
      check("valid", found, 1);
      check("data", frame_data, m_frame);
      check("err", frame_error, m_err);
      check_state("load");
      @(negedge clk);
      check("pulse", frame_valid, 0);
      ser.load = 0; ser.sclk = 0;
      repeat (3) @(negedge clk);
   endtask
   task automatic frame(input int n, input logic [31:0] v, input bit coincide = 0);
      send(n, v);
      do_load(coincide);
   endtask
   initial begin
      int n;
      apply_reset();
      frame(16, 'h0C01); frame(16, 'h0B07); frame(16, 'h0130);
      check("raw_seg0", segments[7:0], 8'h30);
      check("raw_rest", segments[63:8], 0);
      frame(16, 'h09FF); frame(16, 'h0285);
      check("cb_dp5", segments[15:8], 8'hDB);
      frame(16, 'h028F);
      check("cb_dpblank", segments[15:8], 8'h80);
      frame(16, 'h0B02); frame(16, 'h047F);
      check("scan_blank", segments[31:24], 8'h00);
      frame(16, 'h0F01);
      check("test_all", segments, 64'hFFFF_FFFF_FFFF_FFFF);
      frame(16, 'h0F00);
      send(12, 'h5A7); do_load(0);
      check("short_err", frame_error, 1);
      frame(20, 'hF0A0B);
      check("long_err", frame_error, 0);
      check("long_int", intensity, 4'hB);
      send(16, 'h0466); do_load(1);
      check("coinc_data", frame_data, 16'h0466);
      send(8, 'hAB);
      apply_reset();
      frame(16, 'h0342);
      check("rst_mid_err", frame_error, 0);
      frame(16, 'h0C01); frame(16, 'h0B07);
      check("rst_mid_dig2", segments[23:16], 8'h42);
      for (int i = 0; i < 30; i++) begin
         n = $urandom_range(10, 22);
         frame(n, $urandom, $urandom_range(0, 5) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
